// File: rtl/ddr2_req_pkg.sv
// Shared encodings and helpers for the DDR2 request arbiter.
package ddr2_req_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WDATA = 2'd2
  } arb_state_e;

  // Client index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ddr2_req_arbiter_tag_fifo.sv
// First-word-fall-through FIFO of client ids for outstanding reads.
module sync_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign do_push = push & (count_reg != (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ddr2_req_arbiter.sv
// Round-robin arbiter of N clients onto the shared DDR2 af/wdf FIFOs,
// with in-order routing of rdf beats back to the issuing client.
module ddr2_req_arbiter
  import ddr2_req_pkg::*;
#(
  parameter int NUM_CLIENTS = 8,
  parameter int ADDR_W      = 31,
  parameter int DATA_W      = 128,
  parameter int MASK_W      = 16,
  parameter int WR_BEATS    = 2,
  parameter int RD_BEATS    = 2,
  parameter int TAG_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        cl_af_wr_en,
  input  logic [3*NUM_CLIENTS-1:0]      cl_af_cmd_din,
  input  logic [ADDR_W*NUM_CLIENTS-1:0] cl_af_addr_din,
  input  logic [NUM_CLIENTS-1:0]        cl_wdf_wr_en,
  input  logic [DATA_W*NUM_CLIENTS-1:0] cl_wdf_din,
  input  logic [MASK_W*NUM_CLIENTS-1:0] cl_wdf_mask_din,
  input  logic [NUM_CLIENTS-1:0]        cl_rdf_rd_en,
  output logic [NUM_CLIENTS-1:0]        cl_af_full,
  output logic [NUM_CLIENTS-1:0]        cl_wdf_full,
  output logic [NUM_CLIENTS-1:0]        cl_rdf_valid,
  input  logic                          af_full,
  output logic                          af_wr_en,
  output logic [2:0]                    af_cmd_din,
  output logic [ADDR_W-1:0]             af_addr_din,
  input  logic                          wdf_full,
  output logic                          wdf_wr_en,
  output logic [DATA_W-1:0]             wdf_din,
  output logic [MASK_W-1:0]             wdf_mask_din,
  input  logic                          rdf_valid,
  output logic                          rdf_rd_en,
  output logic                          err_orphan_rd
);

  localparam int IW  = idx_width(NUM_CLIENTS);
  localparam int CW  = $clog2(TAG_DEPTH) + 1;
  localparam int WBW = $clog2(WR_BEATS + 1);
  localparam int RBW = $clog2(RD_BEATS + 1);

  arb_state_e       state_reg, state_next;
  logic [IW-1:0]    g_reg, g_next;
  logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [WBW-1:0]   wbeat_reg, wbeat_next;
  logic [RBW-1:0]   rbeat_reg;
  logic             err_orphan_rd_reg;

  logic [2:0]        cmd_arr   [NUM_CLIENTS];
  logic [ADDR_W-1:0] addr_arr  [NUM_CLIENTS];
  logic [DATA_W-1:0] wdata_arr [NUM_CLIENTS];
  logic [MASK_W-1:0] mask_arr  [NUM_CLIENTS];

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             grant_blocked;
  logic             accept;
  logic             rd_block;
  logic             tag_push;
  logic             tag_pop;
  logic             tag_empty;
  logic [IW-1:0]    tag_head;
  logic [CW-1:0]    tag_count;
  logic             rbeat_last;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_CLIENTS - 1)) ? '0 : i + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      assign cmd_arr[gi]   = cl_af_cmd_din[gi*3 +: 3];
      assign addr_arr[gi]  = cl_af_addr_din[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = cl_wdf_din[gi*DATA_W +: DATA_W];
      assign mask_arr[gi]  = cl_wdf_mask_din[gi*MASK_W +: MASK_W];

      assign cl_af_full[gi]   = (state_reg == ST_GRANT && g_reg == IW'(gi)) ? grant_blocked : 1'b1;
      assign cl_wdf_full[gi]  = (state_reg == ST_WDATA && g_reg == IW'(gi)) ? wdf_full : 1'b1;
      assign cl_rdf_valid[gi] = rdf_valid & ~tag_empty & (tag_head == IW'(gi));
    end
  endgenerate

  // Scan from the highest offset down so the nearest requester to rr_ptr wins.
  always_comb begin
    int c;
    c          = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      c = (int'(rr_ptr_reg) + k) % NUM_CLIENTS;
      if (cl_af_wr_en[c]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(c);
      end
    end
  end

  assign rd_block      = (tag_count == CW'(TAG_DEPTH));
  assign grant_blocked = af_full | rd_block;
  assign accept        = (state_reg == ST_GRANT) & cl_af_wr_en[g_reg] & ~grant_blocked;

  assign af_cmd_din   = cmd_arr[g_reg];
  assign af_addr_din  = addr_arr[g_reg];
  assign wdf_din      = wdata_arr[g_reg];
  assign wdf_mask_din = mask_arr[g_reg];

  always_comb begin
    state_next  = state_reg;
    g_next      = g_reg;
    rr_ptr_next = rr_ptr_reg;
    wbeat_next  = wbeat_reg;
    af_wr_en    = 1'b0;
    wdf_wr_en   = 1'b0;
    tag_push    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          g_next     = pick_idx;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          af_wr_en = 1'b1;
          if (cmd_arr[g_reg] == CMD_READ) begin
            tag_push    = 1'b1;
            rr_ptr_next = next_idx(g_reg);
            state_next  = ST_IDLE;
          end else begin
            wbeat_next = '0;
            state_next = ST_WDATA;
          end
        end else if (!cl_af_wr_en[g_reg]) begin
          state_next = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (cl_wdf_wr_en[g_reg] && !wdf_full) begin
          wdf_wr_en = 1'b1;
          if (wbeat_reg == WBW'(WR_BEATS - 1)) begin
            wbeat_next  = '0;
            rr_ptr_next = next_idx(g_reg);
            state_next  = ST_IDLE;
          end else begin
            wbeat_next = wbeat_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      g_reg      <= '0;
      rr_ptr_reg <= '0;
      wbeat_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      g_reg      <= g_next;
      rr_ptr_reg <= rr_ptr_next;
      wbeat_reg  <= wbeat_next;
    end
  end

  // Read return is independent of the command FSM.
  assign rdf_rd_en  = cl_rdf_rd_en[tag_head] & cl_rdf_valid[tag_head];
  assign rbeat_last = (rbeat_reg == RBW'(RD_BEATS - 1));
  assign tag_pop    = rdf_rd_en & rbeat_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      rbeat_reg         <= '0;
      err_orphan_rd_reg <= 1'b0;
    end else begin
      if (rdf_rd_en) rbeat_reg <= rbeat_last ? '0 : rbeat_reg + 1'b1;
      if (rdf_valid && tag_empty) err_orphan_rd_reg <= 1'b1;
    end
  end

  assign err_orphan_rd = err_orphan_rd_reg;

  sync_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (IW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (g_reg),
    .pop   (tag_pop),
    .dout  (tag_head),
    .empty (tag_empty),
    .count (tag_count)
  );

endmodule

// File: tb/tb_ddr2_req_arbiter.sv
// Directed bench for ddr2_req_arbiter: arbitration, write ownership, read routing, tag back-pressure.
module tb_ddr2_req_arbiter;
  import ddr2_req_pkg::*;

  localparam int N  = 8;
  localparam int AW = 31;
  localparam int DW = 128;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    cl_af_wr_en, cl_wdf_wr_en, cl_rdf_rd_en;
  logic [3*N-1:0]  cl_af_cmd_din;
  logic [AW*N-1:0] cl_af_addr_din;
  logic [DW*N-1:0] cl_wdf_din;
  logic [MW*N-1:0] cl_wdf_mask_din;
  logic [N-1:0]    cl_af_full, cl_wdf_full, cl_rdf_valid;
  logic            af_full, af_wr_en, wdf_full, wdf_wr_en, rdf_valid, rdf_rd_en, err_orphan_rd;
  logic [2:0]      af_cmd_din;
  logic [AW-1:0]   af_addr_din;
  logic [DW-1:0]   wdf_din;
  logic [MW-1:0]   wdf_mask_din;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [DW-1:0] D0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [DW-1:0] D1 = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;

  always #5 clk = ~clk;

  ddr2_req_arbiter #(
    .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
    .WR_BEATS(2), .RD_BEATS(2), .TAG_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cl_af_wr_en(cl_af_wr_en), .cl_af_cmd_din(cl_af_cmd_din), .cl_af_addr_din(cl_af_addr_din),
    .cl_wdf_wr_en(cl_wdf_wr_en), .cl_wdf_din(cl_wdf_din), .cl_wdf_mask_din(cl_wdf_mask_din),
    .cl_rdf_rd_en(cl_rdf_rd_en),
    .cl_af_full(cl_af_full), .cl_wdf_full(cl_wdf_full), .cl_rdf_valid(cl_rdf_valid),
    .af_full(af_full), .af_wr_en(af_wr_en), .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din),
    .wdf_full(wdf_full), .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din),
    .rdf_valid(rdf_valid), .rdf_rd_en(rdf_rd_en), .err_orphan_rd(err_orphan_rd)
  );

  // One line per FIFO transaction.
  always @(posedge clk) begin
    if (!rst && af_wr_en)  $display("txn af  cmd=%0d addr=%0h", af_cmd_din, af_addr_din);
    if (!rst && wdf_wr_en) $display("txn wdf data=%0h mask=%0h", wdf_din, wdf_mask_din);
    if (!rst && rdf_rd_en) $display("txn rdf pop clients=%b", cl_rdf_valid);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int c, input logic [2:0] cmd, input logic [AW-1:0] addr);
    cl_af_cmd_din[c*3 +: 3]    = cmd;
    cl_af_addr_din[c*AW +: AW] = addr;
  endtask

  initial begin
    logic [N-1:0] exp_v;
    int heads2 [4];
    int heads5 [6];
    heads2 = '{2, 2, 5, 5};
    heads5 = '{7, 7, 0, 0, 1, 1};

    // 1: reset with every input asserted
    rst = 1'b1;
    cl_af_wr_en = '1; cl_af_cmd_din = '1; cl_af_addr_din = '1;
    cl_wdf_wr_en = '1; cl_wdf_din = '1; cl_wdf_mask_din = '1; cl_rdf_rd_en = '1;
    af_full = 1'b1; wdf_full = 1'b1; rdf_valid = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_cl_af_full", cl_af_full, 8'hFF);
    chk("rst_cl_wdf_full", cl_wdf_full, 8'hFF);
    chk("rst_cl_rdf_valid", cl_rdf_valid, 8'h00);
    chk("rst_af_wr_en", af_wr_en, 1'b0);
    chk("rst_wdf_wr_en", wdf_wr_en, 1'b0);
    chk("rst_rdf_rd_en", rdf_rd_en, 1'b0);
    chk("rst_err", err_orphan_rd, 1'b0);
    step();
    rst = 1'b0;
    cl_af_wr_en = '0; cl_af_cmd_din = '0; cl_af_addr_din = '0;
    cl_wdf_wr_en = '0; cl_wdf_din = '0; cl_wdf_mask_din = '0; cl_rdf_rd_en = '0;
    af_full = 1'b0; wdf_full = 1'b0; rdf_valid = 1'b0;

    // 2: clients 2 and 5 read together from rr_ptr=0
    set_cmd(2, CMD_READ, 31'h22);
    set_cmd(5, CMD_READ, 31'h55);
    cl_af_wr_en = 8'b0010_0100;
    step();
    @(negedge clk);
    chk("t2_g2_af_wr_en", af_wr_en, 1'b1);
    chk("t2_g2_addr", af_addr_din, 31'h22);
    chk("t2_g2_cmd", af_cmd_din, CMD_READ);
    chk("t2_g2_cl_af_full", cl_af_full, 8'hFB);
    step();
    cl_af_wr_en[2] = 1'b0;
    @(negedge clk);
    chk("t2_idle_gap", af_wr_en, 1'b0);
    step();
    @(negedge clk);
    chk("t2_g5_af_wr_en", af_wr_en, 1'b1);
    chk("t2_g5_addr", af_addr_din, 31'h55);
    chk("t2_g5_cl_af_full", cl_af_full, 8'hDF);
    step();
    cl_af_wr_en = '0;
    rdf_valid = 1'b1;
    cl_rdf_rd_en = '1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      exp_v = 8'(1 << heads2[b]);
      $display("rdf beat data=%0h expected at client %0d", 4'hA + b, heads2[b]);
      chk("t2_rdf_route", cl_rdf_valid, exp_v);
      chk("t2_rdf_pop", rdf_rd_en, 1'b1);
      step();
    end
    rdf_valid = 1'b0;

    // 3: client 3 write burst owns the bus; client 1 waits (rr_ptr now 6)
    set_cmd(3, CMD_WRITE, 31'h100);
    cl_af_wr_en = 8'b0000_1000;
    cl_wdf_din[3*DW +: DW] = D0;
    cl_wdf_mask_din[3*MW +: MW] = 16'h00F0;
    cl_wdf_din[1*DW +: DW] = 128'hDEAD;
    cl_wdf_mask_din[1*MW +: MW] = 16'hFFFF;
    cl_wdf_wr_en[1] = 1'b1;
    step();
    set_cmd(1, CMD_READ, 31'h11);
    cl_af_wr_en[1] = 1'b1;
    @(negedge clk);
    chk("t3_wr_af_wr_en", af_wr_en, 1'b1);
    chk("t3_wr_addr", af_addr_din, 31'h100);
    chk("t3_wr_cmd", af_cmd_din, CMD_WRITE);
    chk("t3_wr_cl_af_full", cl_af_full, 8'hF7);
    step();
    cl_af_wr_en[3] = 1'b0;
    wdf_full = 1'b1;
    cl_wdf_wr_en[3] = 1'b1;
    @(negedge clk);
    chk("t3_wdf_stall", wdf_wr_en, 1'b0);
    chk("t3_stall_cl_wdf_full", cl_wdf_full, 8'hFF);
    chk("t3_wdata_cl_af_full", cl_af_full, 8'hFF);
    chk("t3_wdata_af_wr_en", af_wr_en, 1'b0);
    step();
    wdf_full = 1'b0;
    @(negedge clk);
    chk("t3_d0_wr_en", wdf_wr_en, 1'b1);
    chk("t3_d0_data", wdf_din, D0);
    chk("t3_d0_mask", wdf_mask_din, 16'h00F0);
    chk("t3_d0_cl_wdf_full", cl_wdf_full, 8'hF7);
    step();
    cl_wdf_din[3*DW +: DW] = D1;
    @(negedge clk);
    chk("t3_d1_wr_en", wdf_wr_en, 1'b1);
    chk("t3_d1_data", wdf_din, D1);
    chk("t3_d1_no_cmd", af_wr_en, 1'b0);
    step();
    cl_wdf_wr_en = '0;
    @(negedge clk);
    chk("t3_after_cl_wdf_full", cl_wdf_full, 8'hFF);
    chk("t3_after_no_cmd", af_wr_en, 1'b0);
    step();
    @(negedge clk);
    chk("t3_g1_af_wr_en", af_wr_en, 1'b1);
    chk("t3_g1_addr", af_addr_din, 31'h11);
    chk("t3_g1_cl_af_full", cl_af_full, 8'hFD);
    step();
    cl_af_wr_en = '0;
    rdf_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      chk("t3_rdf_route", cl_rdf_valid, 8'h02);
      step();
    end
    rdf_valid = 1'b0;

    // 4: 16 outstanding reads fill the tag FIFO; the 17th waits for a full return
    set_cmd(0, CMD_READ, 31'h40);
    cl_af_wr_en = 8'h01;
    cl_rdf_rd_en = 8'h01;
    for (int i = 0; i < 16; i++) begin
      step();
      @(negedge clk);
      chk("t4_accept", af_wr_en, 1'b1);
      step();
    end
    step();
    @(negedge clk);
    chk("t4_blocked", af_wr_en, 1'b0);
    chk("t4_blocked_cl_af_full", cl_af_full, 8'hFF);
    step();
    rdf_valid = 1'b1;
    @(negedge clk);
    chk("t4_beat0_pop", rdf_rd_en, 1'b1);
    chk("t4_beat0_blocked", af_wr_en, 1'b0);
    step();
    @(negedge clk);
    chk("t4_pop_same_cycle", af_wr_en, 1'b0);
    step();
    rdf_valid = 1'b0;
    @(negedge clk);
    chk("t4_unblocked", af_wr_en, 1'b1);
    step();
    cl_af_wr_en = '0;
    rdf_valid = 1'b1;
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      chk("t4_drain", cl_rdf_valid, 8'h01);
      step();
    end
    rdf_valid = 1'b0;
    cl_rdf_rd_en = '0;

    // 5: client 7 then client 0 (rr_ptr wraps 7 -> 0), head-only valid
    set_cmd(7, CMD_READ, 31'h77);
    cl_af_wr_en = 8'h80;
    step();
    @(negedge clk);
    chk("t5_g7_addr", af_addr_din, 31'h77);
    chk("t5_g7_af_wr_en", af_wr_en, 1'b1);
    step();
    set_cmd(0, CMD_READ, 31'h0A);
    set_cmd(1, CMD_READ, 31'h1A);
    cl_af_wr_en = 8'h03;
    step();
    @(negedge clk);
    chk("t5_wrap_addr", af_addr_din, 31'h0A);
    chk("t5_wrap_cl_af_full", cl_af_full, 8'hFE);
    step();
    cl_af_wr_en = 8'h02;
    step();
    @(negedge clk);
    chk("t5_g1_addr", af_addr_din, 31'h1A);
    step();
    cl_af_wr_en = '0;
    rdf_valid = 1'b1;
    cl_rdf_rd_en = 8'h7F;
    @(negedge clk);
    chk("t5_head_only", cl_rdf_valid, 8'h80);
    chk("t5_head_not_popping", rdf_rd_en, 1'b0);
    step();
    cl_rdf_rd_en = '1;
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      exp_v = 8'(1 << heads5[b]);
      chk("t5_rdf_route", cl_rdf_valid, exp_v);
      step();
    end
    rdf_valid = 1'b0;

    // 6: orphan read data
    rdf_valid = 1'b1;
    @(negedge clk);
    chk("t6_no_pop", rdf_rd_en, 1'b0);
    chk("t6_no_valid", cl_rdf_valid, 8'h00);
    chk("t6_err_before", err_orphan_rd, 1'b0);
    step();
    rdf_valid = 1'b0;
    @(negedge clk);
    chk("t6_err_set", err_orphan_rd, 1'b1);
    step();
    @(negedge clk);
    chk("t6_err_sticky", err_orphan_rd, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_err_cleared", err_orphan_rd, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
